// File: rtl/rv32i_pkg.sv
// Shared rv32i front-end constants: default widths, PC increment and the IF/ID bubble encoding.
package rv32i_pkg;
  localparam int unsigned PCSIZE_DEFAULT   = 32;
  localparam int unsigned ISTRSIZE_DEFAULT = 32;
  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] BUBBLE_INSTR     = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy; push on full is accepted when a pop frees a slot.
module fetch_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read while counted in level_q.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/if_fetch_stage.sv
// rv32i instruction-fetch stage: PC, imem req/gnt/rvalid handshake, epoch-tagged response filtering.
// Optional misaligned-redirect fault state enabled by defining IF_MISALIGN_TRAP_EN.
module if_fetch_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned       PCSIZE     = PCSIZE_DEFAULT,
  parameter int unsigned       ISTRSIZE   = ISTRSIZE_DEFAULT,
  parameter logic [PCSIZE-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                r,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PCSIZE-1:0]   redirect_pc,
  output logic                imem_req_o,
  output logic [PCSIZE-1:0]   imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [ISTRSIZE-1:0] imem_rdata_i,
  output logic [ISTRSIZE-1:0] if_instr_o,
  output logic [PCSIZE-1:0]   if_pc_o,
  output logic                if_valid_o,
  output logic                if_misalign_o
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = PCSIZE + ISTRSIZE;

  logic [PCSIZE-1:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d, tgt_pc, buf_pc;
  logic [ISTRSIZE-1:0] buf_instr;
  logic [BW-1:0]       buf_dout;
  logic [CW-1:0]       count_q, count_d, pend_level, buf_level;
  logic [0:0]          pend_tag;
  logic                epoch_q, epoch_d, fault_c;
  logic                pend_empty, pend_full, buf_empty, buf_full;
  logic                fire, rsp_ok, rsp_fresh, buf_push, pop;

`ifdef IF_MISALIGN_TRAP_EN
  logic fault_q, fault_d, tgt_misalign;

  assign tgt_pc       = redirect_pc;
  assign tgt_misalign = |redirect_pc[1:0];
  assign fault_c      = fault_q;

  always_comb begin
    fault_d = fault_q;
    if (redirect) fault_d = tgt_misalign;
  end

  always_ff @(posedge clk) begin
    if (r) fault_q <= 1'b0;
    else   fault_q <= fault_d;
  end
`else
  assign tgt_pc  = redirect_pc & ~PCSIZE'(3);
  assign fault_c = 1'b0;
`endif

  assign imem_req_o  = !r && !redirect && !fault_c && (count_q < CW'(FIFO_DEPTH));
  assign imem_addr_o = pc_q;
  assign fire        = imem_req_o && imem_gnt_i;
  assign rsp_ok      = imem_rvalid_i && !pend_empty;
  assign rsp_fresh   = (pend_tag == epoch_q);
  assign buf_push    = rsp_ok && rsp_fresh && !redirect;
  assign pop         = !r && !redirect && !stall && !buf_empty;

  assign {buf_pc, buf_instr} = buf_dout;
  assign if_valid_o    = !r && (fault_c || !buf_empty);
  assign if_misalign_o = !r && fault_c;
  assign if_pc_o       = !if_valid_o ? '0 : (fault_c ? pc_q : buf_pc);
  assign if_instr_o    = (if_valid_o && !fault_c) ? buf_instr : ISTRSIZE'(BUBBLE_INSTR);

  // Epoch captured at grant; compared on return to drop responses older than a redirect.
  fetch_fifo #(.WIDTH(1), .DEPTH(FIFO_DEPTH)) u_pend (
    .clk     (clk),
    .rst_i   (r),
    .flush_i (1'b0),
    .push_i  (fire),
    .data_i  (epoch_q),
    .pop_i   (rsp_ok),
    .data_o  (pend_tag),
    .full_o  (pend_full),
    .empty_o (pend_empty),
    .level_o (pend_level)
  );

  fetch_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_ibuf (
    .clk     (clk),
    .rst_i   (r),
    .flush_i (redirect),
    .push_i  (buf_push),
    .data_i  ({rsp_pc_q, imem_rdata_i}),
    .pop_i   (pop),
    .data_o  (buf_dout),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .level_o (buf_level)
  );

  // rsp_pc tracks the PC of the next live response, so the pending queue only carries the epoch.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    epoch_d  = epoch_q;
    count_d  = count_q;
    if (redirect) begin
      pc_d     = tgt_pc;
      rsp_pc_d = tgt_pc;
      epoch_d  = !epoch_q;
      count_d  = count_q - buf_level - CW'(rsp_ok);
    end else begin
      if (fire)     pc_d     = pc_q + PCSIZE'(PC_STEP);
      if (buf_push) rsp_pc_d = rsp_pc_q + PCSIZE'(PC_STEP);
      count_d = count_q + CW'(fire) - CW'(rsp_ok && !rsp_fresh) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      epoch_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      epoch_q  <= epoch_d;
      count_q  <= count_d;
    end
  end

  // Simulation-only protocol and bookkeeping checks.
  always_ff @(posedge clk) begin
    if (!r) begin
      assert (!(imem_rvalid_i && pend_empty))
        else $error("if_fetch_stage: rvalid with no outstanding request");
      assert (count_q == CW'(pend_level + buf_level))
        else $error("if_fetch_stage: count out of step with queues");
      assert (!(fire && pend_full))
        else $error("if_fetch_stage: pending queue overflow");
      assert (!(buf_push && buf_full && !pop))
        else $error("if_fetch_stage: instruction buffer overflow");
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: in-order latency memory model plus a queue-based fetch reference.
module tb_if_fetch_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        r, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic [31:0] if_instr_o, if_pc_o;
  logic        if_valid_o, if_misalign_o;

  if_fetch_stage dut (
    .clk(clk), .r(r), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .if_instr_o(if_instr_o), .if_pc_o(if_pc_o), .if_valid_o(if_valid_o),
    .if_misalign_o(if_misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } bent_t;

  mreq_t       mq[$];   // granted requests awaiting a response, in order
  bent_t       bq[$];   // live fetched words not yet consumed by decode
  logic [31:0] fetch_pc, fpc, salt;
  bit          fault;
  int          stale_n, cyc, last_due, lat_min, lat_max;
  int          n_cmp, n_fail;
  logic [98:0] obs, exp_v;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Drive one cycle, record observed/expected {valid,misalign,pc,instr,req,addr}, advance the model.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic gn);
    bit          rv, ev, er, pop;
    logic [31:0] epc, eins;
    mreq_t       m;
    int          d;
    rv = (mq.size() > 0) && (mq[0].due <= cyc);
    stall = st; redirect = rd; redirect_pc = rpc; imem_gnt_i = gn;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? word(mq[0].addr) : $urandom();
    #1;
    ev    = fault || (bq.size() > 0);
    epc   = fault ? fpc : ((bq.size() > 0) ? bq[0].pc : 32'h0);
    eins  = (!fault && bq.size() > 0) ? bq[0].instr : 32'h0;
    er    = !rd && !fault && (mq.size() + bq.size() < DEPTH);
    exp_v = {ev, fault, epc, eins, er, er ? fetch_pc : 32'h0};
    obs   = {if_valid_o, if_misalign_o, if_pc_o, if_instr_o, imem_req_o, er ? imem_addr_o : 32'h0};
    pop = ev && !fault && !st && !rd;
    if (pop) bq.delete(0);
    if (rv) begin
      m = mq.pop_front();
      if (stale_n > 0) stale_n--;
      else if (!rd) bq.push_back('{pc: m.addr, instr: word(m.addr)});
    end
    if (rd) begin
      bq.delete();
      stale_n = mq.size();
`ifdef IF_MISALIGN_TRAP_EN
      fault    = (rpc[1:0] != 2'b00);
      fpc      = rpc;
      fetch_pc = rpc;
`else
      fetch_pc = rpc & 32'hFFFF_FFFC;
`endif
    end else if (er && gn) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d < last_due) d = last_due;
      last_due = d;
      mq.push_back('{addr: fetch_pc, due: d});
      fetch_pc = fetch_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    r = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    #1;
    n_cmp++;
    if ({if_valid_o, if_misalign_o, if_pc_o, if_instr_o, imem_req_o} !== 67'h0) begin
      n_fail++;
      $display("FAIL reset_in got v=%b m=%b pc=%h i=%h req=%b want all 0",
               if_valid_o, if_misalign_o, if_pc_o, if_instr_o, imem_req_o);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({if_valid_o, if_misalign_o, if_pc_o, if_instr_o, imem_req_o} !== 67'h0) begin
      n_fail++;
      $display("FAIL reset_hold got v=%b m=%b pc=%h i=%h req=%b want all 0",
               if_valid_o, if_misalign_o, if_pc_o, if_instr_o, imem_req_o);
    end
    mq.delete(); bq.delete();
    fetch_pc = 32'h0; fpc = 32'h0; fault = 1'b0; stale_n = 0; last_due = 0;
    r = 1'b0;
  endtask

  task automatic test_stream();
    test_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL stream cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
    end
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    test_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20 && !found; i++) begin
      if (if_valid_o && if_pc_o == 32'h8) found = 1'b1;
      else begin
        step(1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL stall_pre cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
      end
    end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL stall_reach got pc=%h want 00000008 within 20 cycles", if_pc_o); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL stall cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
      n_cmp++;
      if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8) begin
        n_fail++; $display("FAIL stall_hold got v=%b pc=%h want v=1 pc=00000008", if_valid_o, if_pc_o);
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL stall_post cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
    end
  endtask

  task automatic test_redirect();
    test_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && mq.size() < 2; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (mq.size() != 2) begin n_fail++; $display("FAIL redir_setup got inflight=%0d want 2", mq.size()); end
    step(1'b0, 1'b1, 32'h100, 1'b1);
    n_cmp++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL redir cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL redir_post cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
      n_cmp++;
      if (if_valid_o && (if_pc_o < 32'h100 || if_pc_o >= 32'h200)) begin
        n_fail++; $display("FAIL redir_stale got pc=%h want 00000100..000001ff", if_pc_o);
      end
    end
  endtask

  task automatic test_redirect_stall();
    test_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h300, 1'b1);
    n_cmp++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL redir_stall cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
    n_cmp++;
    if (if_valid_o !== 1'b0 || imem_addr_o !== 32'h300) begin
      n_fail++; $display("FAIL redir_stall_next got v=%b addr=%h want v=0 addr=00000300", if_valid_o, imem_addr_o);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL redir_stall_post cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
    end
  endtask

  task automatic test_gnt_low();
    bit wrapped = 1'b0;
    test_reset();
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL gnt_low cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
      n_cmp++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFF4) begin
        n_fail++; $display("FAIL gnt_hold got req=%b addr=%h want req=1 addr=fffffff4", imem_req_o, imem_addr_o);
      end
    end
    for (int i = 0; i < 14; i++) begin
      if (imem_req_o && imem_addr_o == 32'h0) wrapped = 1'b1;
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL wrap cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
    end
    n_cmp++;
    if (!wrapped) begin n_fail++; $display("FAIL wrap_addr got no request at 00000000 want one after fffffffc"); end
  endtask

`ifdef IF_MISALIGN_TRAP_EN
  task automatic test_misalign();
    test_reset();
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h102, 1'b1);
    for (int i = 0; i < 6 || stale_n > 0; i++) begin
      if (i > 30) break;
      step(1'($urandom_range(1, 0)), 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL misalign cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
      n_cmp++;
      if ({if_valid_o, if_misalign_o, if_pc_o, if_instr_o, imem_req_o} !== {2'b11, 32'h102, 32'h0, 1'b0}) begin
        n_fail++; $display("FAIL misalign_hold got v=%b m=%b pc=%h i=%h req=%b want v=1 m=1 pc=00000102 i=0 req=0",
                           if_valid_o, if_misalign_o, if_pc_o, if_instr_o, imem_req_o);
      end
    end
    step(1'b0, 1'b1, 32'h200, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL misalign_clear cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] rpc;
    logic        rd;
    test_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) test_reset();
      rd  = (stale_n == 0) && ($urandom_range(11, 0) == 0);
      rpc = ($urandom_range(4, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
      if ($urandom_range(7, 0) == 0) rpc = rpc | 32'($urandom_range(3, 1));
      step(1'($urandom_range(3, 0) == 0), rd, rpc, 1'($urandom_range(3, 0) != 0));
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got no finish want finish before 30000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; salt = $urandom;
    fault = 1'b0; fpc = '0; fetch_pc = '0; stale_n = 0; last_due = 0;
    lat_min = 1; lat_max = 1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_gnt_low();
`ifdef IF_MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
